// File: rtl/cont_regressivo.sv
`default_nettype none
// ============================================================================
//  Module      : cont_regressivo
//  Description : Two-digit BCD countdown timer. A clamped preset is loaded,
//                counting starts on start, decrements once per tick down to
//                00, then flags expiry and holds until reloaded or reset.
//  Ports       : clk         - system clock, rising-edge active
//                p           - asynchronous active-high reset
//                tick        - single-cycle count enable
//                load        - capture load_units/load_tens (not in RUN)
//                load_units  - BCD preset, units digit
//                load_tens   - BCD preset, tens digit
//                start       - begin or resume counting
//                pause       - suspend counting, keeping the value
//                units/tens  - current BCD digits
//                running     - high while counting
//                expired     - high while the count has run out (level)
//                done        - one-cycle pulse when the count reaches 00
//  Revision    : 1.0 - initial release
// ============================================================================
module cont_regressivo #(
    parameter int unsigned TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       p,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_units,
    input  logic [3:0] load_tens,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       running,
    output logic       expired,
    output logic       done
);

    localparam logic [3:0] c_UNITS_MAX = 4'd9;
    localparam logic [3:0] c_TENS_MAX  = 4'(TENS_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state_q;
    logic [3:0] units_q;
    logic [3:0] tens_q;
    logic       running_q;
    logic       expired_q;
    logic       done_q;

    // Preset digits clamped into the legal BCD range
    logic [3:0] w_load_units;
    logic [3:0] w_load_tens;
    // Count is non-zero (start is only honoured then)
    logic       w_nonzero;
    // The next tick will bring the count to 00
    logic       w_last;

    assign w_load_units = (load_units > c_UNITS_MAX) ? c_UNITS_MAX : load_units;
    assign w_load_tens  = (load_tens  > c_TENS_MAX)  ? c_TENS_MAX  : load_tens;
    assign w_nonzero    = (units_q != 4'd0) || (tens_q != 4'd0);
    assign w_last       = (tens_q == 4'd0) && (units_q == 4'd1);

    always_ff @(posedge clk or posedge p) begin
        if (p) begin
            state_q   <= ST_IDLE;
            units_q   <= 4'd0;
            tens_q    <= 4'd0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Load wins over everything except an active count
            if (load && (state_q != ST_RUN)) begin
                units_q   <= w_load_units;
                tens_q    <= w_load_tens;
                state_q   <= ST_IDLE;
                running_q <= 1'b0;
                expired_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start && w_nonzero) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Pause discards a coincident tick
                        if (pause) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end else if (tick) begin
                            if (units_q != 4'd0) begin
                                units_q <= units_q - 4'd1;
                            end else begin
                                units_q <= c_UNITS_MAX;
                                tens_q  <= tens_q - 4'd1;
                            end
                            if (w_last) begin
                                state_q   <= ST_DONE;
                                running_q <= 1'b0;
                                expired_q <= 1'b1;
                                done_q    <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (start) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        // Held at 00 until load or reset
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                        expired_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign units   = units_q;
    assign tens    = tens_q;
    assign running = running_q;
    assign expired = expired_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cont_regressivo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cont_regressivo
//  Description : Self-checking bench for cont_regressivo: directed vector
//                table, hand-written multi-cycle sequences and randomized
//                stimulus against a decimal reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cont_regressivo;

    localparam int TENS_MAX = 5;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       p = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_units = 4'd0;
    logic [3:0] load_tens = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] units;
    logic [3:0] tens;
    logic       running;
    logic       expired;
    logic       done;

    always #5 clk = ~clk;

    cont_regressivo #(.TENS_MAX(TENS_MAX)) dut (
        .clk        (clk),
        .p          (p),
        .tick       (tick),
        .load       (load),
        .load_units (load_units),
        .load_tens  (load_tens),
        .start      (start),
        .pause      (pause),
        .units      (units),
        .tens       (tens),
        .running    (running),
        .expired    (expired),
        .done       (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: count held as a plain decimal number 0..99
    int m_val = 0;
    int m_st  = M_IDLE;
    bit m_done = 1'b0;

    typedef struct {
        bit         ld;
        logic [3:0] lu;
        logic [3:0] lt;
        bit         st;
        bit         pa;
        bit         tk;
        int         eu;
        int         et;
        bit         er;
        bit         ee;
        bit         ed;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic model_step(bit ld, int lu, int lt, bit st, bit pa, bit tk);
        m_done = 1'b0;
        if (ld && m_st != M_RUN) begin
            m_val = ((lu > 9) ? 9 : lu) + 10 * ((lt > TENS_MAX) ? TENS_MAX : lt);
            m_st  = M_IDLE;
        end else begin
            case (m_st)
                M_IDLE:  if (st && m_val != 0) m_st = M_RUN;
                M_RUN: begin
                    if (pa) m_st = M_PAUSE;
                    else if (tk) begin
                        m_val = m_val - 1;
                        if (m_val == 0) begin
                            m_st   = M_DONE;
                            m_done = 1'b1;
                        end
                    end
                end
                M_PAUSE: if (st) m_st = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, " units"},   int'(units),   m_val % 10);
        chk({tag, " tens"},    int'(tens),    m_val / 10);
        chk({tag, " running"}, int'(running), int'(m_st == M_RUN));
        chk({tag, " expired"}, int'(expired), int'(m_st == M_DONE));
        chk({tag, " done"},    int'(done),    int'(m_done));
    endtask

    // One clock cycle with the given inputs; outputs sampled 1 ns after the edge
    task automatic apply(bit ld, logic [3:0] lu, logic [3:0] lt, bit st, bit pa, bit tk);
        load = ld; load_units = lu; load_tens = lt;
        start = st; pause = pa; tick = tk;
        @(posedge clk);
        model_step(ld, int'(lu), int'(lt), st, pa, tk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock
    task automatic do_reset(string tag);
        @(negedge clk);
        p = 1'b1;
        #2;
        chk({tag, " rst units"},   int'(units),   0);
        chk({tag, " rst tens"},    int'(tens),    0);
        chk({tag, " rst running"}, int'(running), 0);
        chk({tag, " rst expired"}, int'(expired), 0);
        chk({tag, " rst done"},    int'(done),    0);
        m_val = 0; m_st = M_IDLE; m_done = 1'b0;
        @(negedge clk);
        p = 1'b0;
    endtask

    function automatic void add(bit ld, int lu, int lt, bit st, bit pa, bit tk,
                                int eu, int et, bit er, bit ee, bit ed);
        vec_t v;
        v.ld = ld; v.lu = 4'(lu); v.lt = 4'(lt);
        v.st = st; v.pa = pa; v.tk = tk;
        v.eu = eu; v.et = et; v.er = er; v.ee = ee; v.ed = ed;
        tbl.push_back(v);
    endfunction

    initial begin
        int pulses;

        // ---------------- directed vector table ----------------
        //  ld lu lt st pa tk   eu et er ee ed
        add(1, 3, 2, 0, 0, 0,   3, 2, 0, 0, 0);   // load 23
        add(1, 0, 1, 0, 0, 0,   0, 1, 0, 0, 0);   // load 10
        add(0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0);   // start
        add(0, 0, 0, 0, 0, 1,   9, 0, 1, 0, 0);   // borrow -> 09
        add(0, 0, 0, 0, 0, 0,   9, 0, 1, 0, 0);   // no tick holds
        add(0, 0, 0, 1, 0, 0,   9, 0, 1, 0, 0);   // start in RUN ignored
        for (int i = 8; i >= 1; i--)
            add(0, 0, 0, 0, 0, 1, i, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1);   // reaches 00, done pulse
        add(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0);   // tick in DONE ignored
        add(0, 0, 0, 1, 0, 1,   0, 0, 0, 1, 0);   // start in DONE ignored
        add(1, 5, 0, 0, 0, 0,   5, 0, 0, 0, 0);   // load 05
        add(0, 0, 0, 1, 0, 0,   5, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,   4, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,   3, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 1,   3, 0, 0, 0, 0);   // pause discards tick
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0); // ticks ignored in PAUSE
        add(0, 0, 0, 1, 0, 0,   3, 0, 1, 0, 0);   // resume
        add(0, 0, 0, 0, 0, 1,   2, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);
        add(1, 12, 7, 0, 0, 0,  9, 5, 0, 0, 0);   // clamp -> 59
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);   // load 00
        add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);   // start on 00 ignored
        add(1, 1, 1, 1, 0, 0,   1, 1, 0, 0, 0);   // load beats start
        add(0, 0, 0, 1, 0, 0,   1, 1, 1, 0, 0);
        add(1, 5, 2, 0, 0, 0,   1, 1, 1, 0, 0);   // load in RUN ignored
        add(0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0);   // 11 -> 10
        add(0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0);   // pause
        add(0, 0, 0, 1, 1, 1,   0, 1, 1, 0, 0);   // start beats pause in PAUSE
        add(0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0);
        add(1, 3, 0, 1, 0, 0,   3, 0, 0, 0, 0);   // load in PAUSE -> IDLE

        do_reset("init");
        foreach (tbl[i]) begin
            apply(tbl[i].ld, tbl[i].lu, tbl[i].lt, tbl[i].st, tbl[i].pa, tbl[i].tk);
            chk($sformatf("vec%0d units", i),   int'(units),   tbl[i].eu);
            chk($sformatf("vec%0d tens", i),    int'(tens),    tbl[i].et);
            chk($sformatf("vec%0d running", i), int'(running), int'(tbl[i].er));
            chk($sformatf("vec%0d expired", i), int'(expired), int'(tbl[i].ee));
            chk($sformatf("vec%0d done", i),    int'(done),    int'(tbl[i].ed));
        end

        // ---------------- async reset mid-count ----------------
        do_reset("pre_abort");
        apply(1, 4'd5, 4'd4, 0, 0, 0);
        apply(0, 4'd0, 4'd0, 1, 0, 0);
        for (int i = 0; i < 5; i++) apply(0, 4'd0, 4'd0, 0, 0, 1);
        chk("abort units before", int'(units), 0);
        chk("abort tens before",  int'(tens),  4);
        chk("abort running before", int'(running), 1);
        do_reset("abort");
        apply(0, 4'd0, 4'd0, 0, 0, 1);
        check_model("post_abort");
        apply(0, 4'd0, 4'd0, 1, 0, 1);   // start on 00 after reset stays idle
        check_model("post_abort_start");

        // ---------------- full range 59..00 ----------------
        do_reset("full");
        apply(1, 4'd9, 4'd5, 0, 0, 0);
        apply(0, 4'd0, 4'd0, 1, 0, 0);
        pulses = 0;
        for (int i = 1; i <= 59; i++) begin
            apply(0, 4'd0, 4'd0, 0, 0, 1);
            if (done) pulses++;
            chk($sformatf("full step%0d units", i), int'(units), (59 - i) % 10);
            chk($sformatf("full step%0d tens", i),  int'(tens),  (59 - i) / 10);
            check_model($sformatf("full step%0d", i));
        end
        apply(0, 4'd0, 4'd0, 0, 0, 1);
        if (done) pulses++;
        chk("full done pulses", pulses, 1);

        // ---------------- randomized against model ----------------
        do_reset("rand");
        for (int i = 0; i < 3000; i++) begin
            bit         ld, st, pa, tk;
            logic [3:0] lu, lt;
            if ($urandom_range(0, 299) == 0) do_reset($sformatf("rand%0d", i));
            ld = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 7) == 0);
            pa = ($urandom_range(0, 11) == 0);
            tk = ($urandom_range(0, 9) < 6);
            lu = 4'($urandom_range(0, 15));
            lt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            apply(ld, lu, lt, st, pa, tk);
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
